// File: rtl/knn_pkg.sv
// Shared defaults and FSM encoding for the streaming k-nearest selector.
package knn_pkg;

    localparam int DEF_K      = 4;
    localparam int DEF_TYPE_W = 2;
    localparam int DEF_DIST_W = 16;

    // An empty slot holds the largest distance, so any real sample sorts ahead of it.
    localparam logic [DEF_DIST_W-1:0] DIST_EMPTY = '1;

    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_DONE   = 1'b1
    } knn_state_e;

endpackage

// File: rtl/knn_sort_slot.sv
// One cell of the sorted neighbour list: takes the new sample, its left neighbour's
// contents, or holds, depending on where the new distance lands.
module knn_sort_slot
    import knn_pkg::*;
#(
    parameter int TYPE_W = DEF_TYPE_W,
    parameter int DIST_W = DEF_DIST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en_i,
    input  logic              fresh_i,
    input  logic [DIST_W-1:0] new_dist_i,
    input  logic [TYPE_W-1:0] new_type_i,
    input  logic              lt_prev_i,
    input  logic [DIST_W-1:0] prev_dist_i,
    input  logic [TYPE_W-1:0] prev_type_i,
    output logic              lt_o,
    output logic [DIST_W-1:0] dist_o,
    output logic [TYPE_W-1:0] type_o
);

    logic [DIST_W-1:0] dist_q, dist_d, eff_dist, eff_prev_dist;
    logic [TYPE_W-1:0] type_q, type_d, eff_type, eff_prev_type;

    // On the first beat of a set every slot is seen as empty, including the neighbour.
    assign eff_dist      = fresh_i ? '1 : dist_q;
    assign eff_type      = fresh_i ? '0 : type_q;
    assign eff_prev_dist = fresh_i ? '1 : prev_dist_i;
    assign eff_prev_type = fresh_i ? '0 : prev_type_i;

    assign lt_o = (new_dist_i < eff_dist);

    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        dist_d = dist_q;
        type_d = type_q;
        if (shift_en_i) begin
            dist_d = eff_dist;
            type_d = eff_type;
            if (lt_o && !lt_prev_i) begin
                dist_d = new_dist_i;
                type_d = new_type_i;
            end else if (lt_prev_i) begin
                dist_d = eff_prev_dist;
                type_d = eff_prev_type;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all slots shift off the same old values.
    always_ff @(posedge clk) begin
        if (rst) begin
            dist_q <= '1;
            type_q <= '0;
        end else begin
            dist_q <= dist_d;
            type_q <= type_d;
        end
    end

    assign dist_o = dist_q;
    assign type_o = type_q;

endmodule

// File: rtl/k_nearest_sort.sv
// Streaming top-K selector: keeps the K smallest distances of a set in ascending order
// and pulses valid_sort for one cycle after the set's last sample.
module k_nearest_sort
    import knn_pkg::*;
#(
    parameter int K      = DEF_K,
    parameter int TYPE_W = DEF_TYPE_W,
    parameter int DIST_W = DEF_DIST_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DIST_W-1:0]        in_dist,
    input  logic [TYPE_W-1:0]        in_type,
    input  logic                     in_last,
    output logic                     valid_sort,
    output logic [TYPE_W*K-1:0]      k_nearest_neighbours_type,
    output logic [DIST_W*K-1:0]      k_nearest_neighbours_dist,
    output logic [$clog2(K+1)-1:0]   neighbour_count
);

    localparam int CNT_W = $clog2(K+1);

    knn_state_e         state_q, state_d;
    logic               fresh_q, fresh_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               accept;

    logic [K-1:0]       lt;
    logic [DIST_W-1:0]  slot_dist [K];
    logic [TYPE_W-1:0]  slot_type [K];

    // Outputs are forced low while rst is held so nothing is accepted or reported during reset.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        valid_sort = 1'b0;
        unique case (state_q)
            ST_ACCEPT: begin
                in_ready = !rst;
                if (in_valid && in_ready && in_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                valid_sort = !rst;
                state_d    = ST_ACCEPT;
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        fresh_d = fresh_q;
        count_d = count_q;
        if (state_q == ST_DONE) begin
            fresh_d = 1'b1;
        end else if (accept) begin
            fresh_d = 1'b0;
            if (fresh_q)                     count_d = CNT_W'(1);
            else if (count_q != CNT_W'(K))   count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACCEPT;
            fresh_q <= 1'b1;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            fresh_q <= fresh_d;
            count_q <= count_d;
        end
    end

    for (genvar i = 0; i < K; i++) begin : g_slot
        logic              lt_prev;
        logic [DIST_W-1:0] prev_dist;
        logic [TYPE_W-1:0] prev_type;

        if (i == 0) begin : g_head
            assign lt_prev   = 1'b0;
            assign prev_dist = '1;
            assign prev_type = '0;
        end else begin : g_body
            assign lt_prev   = lt[i-1];
            assign prev_dist = slot_dist[i-1];
            assign prev_type = slot_type[i-1];
        end

        knn_sort_slot #(
            .TYPE_W (TYPE_W),
            .DIST_W (DIST_W)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .shift_en_i  (accept),
            .fresh_i     (fresh_q),
            .new_dist_i  (in_dist),
            .new_type_i  (in_type),
            .lt_prev_i   (lt_prev),
            .prev_dist_i (prev_dist),
            .prev_type_i (prev_type),
            .lt_o        (lt[i]),
            .dist_o      (slot_dist[i]),
            .type_o      (slot_type[i])
        );

        assign k_nearest_neighbours_dist[i*DIST_W +: DIST_W] = slot_dist[i];
        assign k_nearest_neighbours_type[i*TYPE_W +: TYPE_W] = slot_type[i];
    end

    assign neighbour_count = count_q;

endmodule

// File: tb/tb_k_nearest_sort.sv
// Self-checking bench for k_nearest_sort: directed sets with literal expectations plus
// randomized traffic compared every cycle against a sorted-list reference model.
module tb_k_nearest_sort;

    localparam int K  = 4;
    localparam int TW = 2;
    localparam int DW = 8;
    localparam int CW = $clog2(K+1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_dist = '0;
    logic [TW-1:0]   in_type = '0;
    logic            in_last = 1'b0;
    logic            valid_sort;
    logic [TW*K-1:0] k_nearest_neighbours_type;
    logic [DW*K-1:0] k_nearest_neighbours_dist;
    logic [CW-1:0]   neighbour_count;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    k_nearest_sort #(.K(K), .TYPE_W(TW), .DIST_W(DW)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .in_valid                  (in_valid),
        .in_ready                  (in_ready),
        .in_dist                   (in_dist),
        .in_type                   (in_type),
        .in_last                   (in_last),
        .valid_sort                (valid_sort),
        .k_nearest_neighbours_type (k_nearest_neighbours_type),
        .k_nearest_neighbours_dist (k_nearest_neighbours_dist),
        .neighbour_count           (neighbour_count)
    );

    // Reference model: an ascending list of K entries where empty entries read as 255/type 0.
    logic [DW-1:0] m_dist [K];
    logic [TW-1:0] m_type [K];
    int            m_count    = 0;
    bit            m_done     = 0;
    bit            m_fresh    = 1;
    bit            m_accepted = 0;
    bit            started    = 0;

    function automatic void model_clear();
        for (int j = 0; j < K; j++) begin
            m_dist[j] = '1;
            m_type[j] = '0;
        end
    endfunction

    function automatic void model_insert(input logic [DW-1:0] d, input logic [TW-1:0] t);
        int pos;
        pos = -1;
        for (int j = 0; j < K; j++)
            if (pos < 0 && d < m_dist[j]) pos = j;
        if (pos >= 0) begin
            for (int j = K-1; j > pos; j--) begin
                m_dist[j] = m_dist[j-1];
                m_type[j] = m_type[j-1];
            end
            m_dist[pos] = d;
            m_type[pos] = t;
        end
    endfunction

    always @(posedge clk) begin
        m_accepted = 0;
        if (rst) begin
            model_clear();
            m_count = 0;
            m_done  = 0;
            m_fresh = 1;
        end else if (m_done) begin
            m_done  = 0;
            m_fresh = 1;
        end else if (in_valid) begin
            m_accepted = 1;
            if (m_fresh) begin
                model_clear();
                m_count = 0;
                m_fresh = 0;
            end
            model_insert(in_dist, in_type);
            if (m_count < K) m_count++;
            if (in_last) m_done = 1;
        end
        started = 1;
    end

    function automatic logic [DW*K-1:0] pack_dist();
        logic [DW*K-1:0] r;
        for (int j = 0; j < K; j++) r[j*DW +: DW] = m_dist[j];
        return r;
    endfunction

    function automatic logic [TW*K-1:0] pack_type();
        logic [TW*K-1:0] r;
        for (int j = 0; j < K; j++) r[j*TW +: TW] = m_type[j];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("model_in_ready",   64'(in_ready),   64'(!rst && !m_done));
            check("model_valid_sort", 64'(valid_sort), 64'(!rst && m_done));
            check("model_count",      64'(neighbour_count), 64'(m_count));
            check("model_dist",       64'(k_nearest_neighbours_dist), 64'(pack_dist()));
            check("model_type",       64'(k_nearest_neighbours_type), 64'(pack_type()));
        end
    end

    // Drives one beat and returns once the model records its acceptance; waits counts cycles.
    task automatic send(input int d, input int t, input bit last, output int waits);
        in_valid = 1'b1;
        in_dist  = DW'(d);
        in_type  = TW'(t);
        in_last  = last;
        waits    = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!m_accepted && waits < 8);
        if (!m_accepted) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: beat dist %0d not taken after %0d cycles", d, waits);
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pin(input string name, input logic [DW*K-1:0] d, input logic [TW*K-1:0] t,
                       input int cnt, input bit vs);
        check({name, "_dist"},  64'(k_nearest_neighbours_dist), 64'(d));
        check({name, "_type"},  64'(k_nearest_neighbours_type), 64'(t));
        check({name, "_count"}, 64'(neighbour_count), 64'(cnt));
        check({name, "_valid"}, 64'(valid_sort), 64'(vs));
    endtask

    int w;

    initial begin
        repeat (2) @(negedge clk);
        pin("reset", 32'hFFFF_FFFF, 8'h00, 0, 1'b0);
        check("reset_in_ready", 64'(in_ready), 64'(0));
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", 64'(in_ready), 64'(1));
        #1;

        // Basic sort
        send(50, 0, 0, w); send(10, 1, 0, w); send(30, 2, 0, w);
        send(20, 3, 0, w); send(40, 0, 1, w);
        pin("basic", 32'h281E_140A, 8'h2D, 4, 1'b1);
        idle(2);

        // Ties keep arrival order
        send(5, 1, 0, w); send(5, 2, 1, w);
        pin("ties", 32'hFFFF_0505, 8'h09, 2, 1'b1);
        idle(1);

        // Eviction of larger distances
        send(9, 1, 0, w); send(8, 2, 0, w); send(7, 3, 0, w);
        send(6, 0, 0, w); send(5, 1, 0, w); send(4, 2, 1, w);
        pin("evict", 32'h0706_0504, 8'hC6, 4, 1'b1);

        // Back-to-back sets, next beat offered during the DONE cycle
        send(3, 2, 1, w);
        check("b2b_done_ready", 64'(in_ready), 64'(0));
        send(8, 1, 0, w);
        check("b2b_held_beat_waits", 64'(w), 64'(2));
        send(2, 3, 1, w);
        pin("b2b", 32'hFFFF_0802, 8'h07, 2, 1'b1);
        idle(1);

        // Reset mid-set discards the partial set
        send(20, 1, 0, w); send(30, 2, 0, w);
        rst = 1'b1;
        @(negedge clk);
        pin("mid_reset", 32'hFFFF_FFFF, 8'h00, 0, 1'b0);
        #1 rst = 1'b0;
        send(7, 1, 0, w); send(6, 2, 1, w);
        pin("after_reset", 32'hFFFF_0706, 8'h06, 2, 1'b1);
        idle(1);

        // All-ones distance is counted but never fills an empty slot
        send(255, 3, 0, w); send(1, 1, 1, w);
        pin("all_ones", 32'hFFFF_FF01, 8'h01, 2, 1'b1);
        send(255, 2, 1, w);
        pin("single_all_ones", 32'hFFFF_FFFF, 8'h00, 1, 1'b1);
        idle(1);

        // Randomized traffic checked by the model every cycle
        for (int n = 0; n < 400; n++) begin
            int r;
            int d;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                rst = 1'b1;
                @(negedge clk);
                #1 rst = 1'b0;
            end else if (r < 15) begin
                idle(int'($urandom_range(1, 3)));
            end else begin
                d = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 15));
                send(d, int'($urandom_range(0, 3)), $urandom_range(0, 4) == 0, w);
            end
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
